// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helper functions for the multi-port register file
//
// Purpose : default geometry, byte-merge helper used by the write/bypass paths,
//           popcount helper used to cross-check the busy counter.
// Ports   : none (package).

package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Widest busy vector the popcount helper accepts (ADDR_W up to 10).
    localparam int MAX_DEPTH  = 1024;

    // Byte-granular merge: the new byte replaces the old one only when enabled.
    function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
        return be ? new_b : old_b;
    endfunction

    function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// rtl/regfile_wr_merge.sv - combinational merge of all write ports targeting one address
//
// Purpose : for a given target address, collapse the NUM_WR write ports into a
//           per-byte mask and value; later (higher-index) ports override earlier
//           ones byte by byte. hit is set by any enabled write to the address,
//           independent of its byte enables.
// Ports   : we/wa/wdata/wbe - packed write port bundle
//           addr            - target register address
//           mask            - bytes written by at least one port
//           value           - winning byte values (only meaningful where mask=1)
//           hit             - some port has we=1 with wa==addr

module regfile_wr_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   wa,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_WR*DATA_W/8-1:0] wbe,
    input  logic [ADDR_W-1:0]          addr,
    output logic [DATA_W/8-1:0]        mask,
    output logic [DATA_W-1:0]          value,
    output logic                       hit
);

    localparam int BE_W = DATA_W / 8;

    always_comb begin
        mask  = '0;
        value = '0;
        hit   = 1'b0;
        // Ascending scan so the highest-index port is the last to assign a byte.
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && (wa[j*ADDR_W +: ADDR_W] == addr)) begin
                hit = 1'b1;
                for (int b = 0; b < BE_W; b++) begin
                    if (wbe[j*BE_W + b]) begin
                        mask[b]         = 1'b1;
                        value[b*8 +: 8] = wdata[j*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with byte enables, bypass and busy scoreboard
//
// Purpose : NUM_RD combinational read ports, NUM_WR byte-masked write ports,
//           optional same-cycle write-to-read forwarding and a per-register
//           busy scoreboard with a registered busy count.
// Ports   : clk, rst_n         - clock, synchronous active-low reset
//           ra, rdata, rbusy   - read addresses, read data, pending-write flags
//           we, wa, wdata, wbe - write ports (higher index wins per byte)
//           rsv_en, rsv_addr   - reserve (mark busy) one register
//           busy_cnt           - number of busy registers

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic [NUM_WR-1:0]          we,
    input  logic [NUM_WR*ADDR_W-1:0]   wa,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_WR*DATA_W/8-1:0] wbe,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  busy_cnt_q;
    logic [CNT_W-1:0]  busy_cnt_d;

    // ------------------------------------------------------------------
    // Per-register next state
    // ------------------------------------------------------------------
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] R_ADDR = ADDR_W'(r);

        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign regs_d[r] = '0;
            assign busy_d[r] = 1'b0;
        end else begin : g_norm
            logic [BE_W-1:0]   wr_mask;
            logic [DATA_W-1:0] wr_value;
            logic              wr_hit;
            logic [DATA_W-1:0] nxt;

            regfile_wr_merge #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NUM_WR (NUM_WR)
            ) u_merge (
                .we    (we),
                .wa    (wa),
                .wdata (wdata),
                .wbe   (wbe),
                .addr  (R_ADDR),
                .mask  (wr_mask),
                .value (wr_value),
                .hit   (wr_hit)
            );

            always_comb begin
                nxt = regs_q[r];
                for (int b = 0; b < BE_W; b++) begin
                    nxt[b*8 +: 8] = be_merge(regs_q[r][b*8 +: 8], wr_value[b*8 +: 8], wr_mask[b]);
                end
            end

            assign regs_d[r] = nxt;
            // Reservation wins over a same-cycle write: it belongs to a newer producer.
            assign busy_d[r] = (rsv_en && (rsv_addr == R_ADDR)) || (busy_q[r] && !wr_hit);
        end
    end

    // Incremental count: +1 per bit rising, -1 per bit falling.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (busy_d[r] && !busy_q[r]) begin
                busy_cnt_d = busy_cnt_d + CNT_W'(1);
            end else if (!busy_d[r] && busy_q[r]) begin
                busy_cnt_d = busy_cnt_d - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_i;
        logic [DATA_W-1:0] rd_v;
        logic              rb_v;

        assign ra_i = ra[i*ADDR_W +: ADDR_W];

        if (BYPASS != 0) begin : g_byp
            logic [BE_W-1:0]   byp_mask;
            logic [DATA_W-1:0] byp_value;
            logic              byp_hit;

            regfile_wr_merge #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NUM_WR (NUM_WR)
            ) u_byp (
                .we    (we),
                .wa    (wa),
                .wdata (wdata),
                .wbe   (wbe),
                .addr  (ra_i),
                .mask  (byp_mask),
                .value (byp_value),
                .hit   (byp_hit)
            );

            always_comb begin
                rd_v = regs_q[ra_i];
                for (int b = 0; b < BE_W; b++) begin
                    rd_v[b*8 +: 8] = be_merge(regs_q[ra_i][b*8 +: 8], byp_value[b*8 +: 8], byp_mask[b]);
                end
            end

            // A same-cycle write completes the pending producer; reservations are not forwarded.
            assign rb_v = busy_q[ra_i] && !byp_hit;
        end else begin : g_nobyp
            assign rd_v = regs_q[ra_i];
            assign rb_v = busy_q[ra_i];
        end

        if (ZERO_REG != 0) begin : g_rz
            assign rdata[i*DATA_W +: DATA_W] = (ra_i == '0) ? '0 : rd_v;
            assign rbusy[i]                  = (ra_i == '0) ? 1'b0 : rb_v;
        end else begin : g_rn
            assign rdata[i*DATA_W +: DATA_W] = rd_v;
            assign rbusy[i]                  = rb_v;
        end
    end

    a_busy_cnt : assert property (@(posedge clk) disable iff (!rst_n)
        (int'(busy_cnt_q) == popcount(MAX_DEPTH'(busy_q))) && (int'(busy_cnt_q) <= DEPTH));

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (bypass and registered-only instances)

module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    localparam int K_RD0    = 0;
    localparam int K_RD1    = 1;
    localparam int K_RB0    = 2;
    localparam int K_RB1    = 3;
    localparam int K_CNT    = 4;
    localparam int K_NB_RD0 = 5;
    localparam int K_NB_RB0 = 6;
    localparam int K_NB_CNT = 7;

    logic                clk;
    logic                rst_n;
    logic [NR*AW-1:0]    ra;
    logic [NW-1:0]       we;
    logic [NW*AW-1:0]    wa;
    logic [NW*DW-1:0]    wdata;
    logic [NW*DW/8-1:0]  wbe;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;

    logic [NR*DW-1:0]    rdata_b, rdata_n;
    logic [NR-1:0]       rbusy_b, rbusy_n;
    logic [AW:0]         busy_cnt_b, busy_cnt_n;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wdata(wdata), .wbe(wbe),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_b)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wdata(wdata), .wbe(wbe),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_RD0:    return rdata_b[31:0];
            K_RD1:    return rdata_b[63:32];
            K_RB0:    return {31'b0, rbusy_b[0]};
            K_RB1:    return {31'b0, rbusy_b[1]};
            K_CNT:    return 32'(busy_cnt_b);
            K_NB_RD0: return rdata_n[31:0];
            K_NB_RB0: return {31'b0, rbusy_n[0]};
            default:  return 32'(busy_cnt_n);
        endcase
    endfunction

    // Monitor: at mid-cycle, retire every expectation scheduled for this cycle.
    chk_t mc;
    logic [31:0] act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mc = q.pop_front();
            n_total++;
            act = actual(mc.kind);
            if (mc.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", mc.name, mc.cyc, cyc);
            end else if (act === mc.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", mc.name, cyc, act, mc.exp);
            end
        end
    end

    // Stimulus helpers; expectations are pushed in nondecreasing cycle order.
    task automatic expect_at(input int kind, input string name, input logic [31:0] v, input int dly);
        chk_t c;
        c.cyc  = cyc + dly;
        c.kind = kind;
        c.name = name;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        we       = '0;
        wa       = '0;
        wdata    = '0;
        wbe      = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        we[p]             = 1'b1;
        wa[p*AW +: AW]    = a;
        wdata[p*DW +: DW] = d;
        wbe[p*4 +: 4]     = be;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ra       = '0;
        we       = '0;
        wa       = '0;
        wdata    = '0;
        wbe      = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        step();
        step();

        // Reset clears contents, busy bits and count; a write during reset is dropped.
        rst_n = 1'b1;
        wr(0, 5'd5, 32'hDEADBEEF, 4'hF);
        set_ra(5'd5, 5'd6);
        expect_at(K_RD0,    "rst_byp_wr", 32'hDEADBEEF, 0);
        expect_at(K_NB_RD0, "rst_nb_old", 32'h0, 0);
        step();
        rst_n = 1'b0;
        wr(0, 5'd5, 32'h12345678, 4'hF);
        rsv(5'd6);
        set_ra(5'd5, 5'd6);
        expect_at(K_NB_RD0, "pre_rst_r5", 32'hDEADBEEF, 0);
        step();
        rst_n = 1'b1;
        set_ra(5'd5, 5'd6);
        expect_at(K_RD0,    "rst_r5",    32'h0, 0);
        expect_at(K_NB_RD0, "rst_nb_r5", 32'h0, 0);
        expect_at(K_RB0,    "rst_rb5",   32'h0, 0);
        expect_at(K_RB1,    "rst_rb6",   32'h0, 0);
        expect_at(K_CNT,    "rst_cnt",   32'h0, 0);
        expect_at(K_NB_CNT, "rst_nbcnt", 32'h0, 0);

        // Bypass versus registered-only read of a same-cycle write.
        step();
        wr(0, 5'd7, 32'h12345678, 4'hF);
        set_ra(5'd7, 5'd0);
        expect_at(K_RD0,    "byp_r7",     32'h12345678, 0);
        expect_at(K_NB_RD0, "nobyp_r7",   32'h0, 0);
        expect_at(K_RD1,    "zero_rd1",   32'h0, 0);
        step();
        set_ra(5'd7, 5'd0);
        expect_at(K_RD0,    "byp_r7_nx",  32'h12345678, 0);
        expect_at(K_NB_RD0, "nobyp_r7_nx", 32'h12345678, 0);

        // Byte enables and per-byte port priority.
        step();
        wr(0, 5'd3, 32'hAAAAAAAA, 4'hF);
        step();
        wr(0, 5'd3, 32'h11111111, 4'hF);
        wr(1, 5'd3, 32'h22222222, 4'h3);
        set_ra(5'd3, 5'd3);
        expect_at(K_RD0,    "prio_byp",   32'h11112222, 0);
        expect_at(K_NB_RD0, "prio_old",   32'hAAAAAAAA, 0);
        step();
        wr(1, 5'd3, 32'h00CC0000, 4'h4);
        set_ra(5'd3, 5'd3);
        expect_at(K_NB_RD0, "prio_r3",    32'h11112222, 0);
        expect_at(K_RD1,    "be2_byp",    32'h11CC2222, 0);
        step();
        set_ra(5'd3, 5'd3);
        expect_at(K_NB_RD0, "be2_r3",     32'h11CC2222, 0);

        // Scoreboard: reserve, write+reserve, write.
        step();
        rsv(5'd9);
        set_ra(5'd9, 5'd0);
        expect_at(K_RB0, "rsv_not_fwd", 32'h0, 0);
        expect_at(K_CNT, "rsv_cnt0",    32'h0, 0);
        step();
        wr(0, 5'd9, 32'h00000099, 4'hF);
        rsv(5'd9);
        set_ra(5'd9, 5'd0);
        expect_at(K_NB_RB0, "rsv_busy",      32'h1, 0);
        expect_at(K_CNT,    "rsv_cnt1",      32'h1, 0);
        expect_at(K_RB0,    "wr_byp_clr",    32'h0, 0);
        expect_at(K_RD0,    "wr_byp_r9",     32'h00000099, 0);
        step();
        wr(1, 5'd9, 32'h000000AB, 4'h1);
        set_ra(5'd9, 5'd0);
        expect_at(K_NB_RB0, "wrrsv_busy",    32'h1, 0);
        expect_at(K_NB_RD0, "wrrsv_data",    32'h00000099, 0);
        expect_at(K_CNT,    "wrrsv_cnt",     32'h1, 0);
        expect_at(K_RB0,    "wr2_byp_clr",   32'h0, 0);
        step();
        set_ra(5'd9, 5'd0);
        expect_at(K_NB_RB0, "wr_clr_busy",   32'h0, 0);
        expect_at(K_CNT,    "wr_clr_cnt",    32'h0, 0);
        expect_at(K_NB_CNT, "wr_clr_nbcnt",  32'h0, 0);
        expect_at(K_NB_RD0, "wr_be_r9",      32'h000000AB, 0);

        // Zero register ignores writes and reservations.
        step();
        wr(0, 5'd0, 32'hFFFFFFFF, 4'hF);
        rsv(5'd0);
        set_ra(5'd0, 5'd0);
        expect_at(K_RD0, "r0_byp",  32'h0, 0);
        expect_at(K_RB0, "r0_rb",   32'h0, 0);
        step();
        set_ra(5'd0, 5'd0);
        expect_at(K_RD0,    "r0_rd",    32'h0, 0);
        expect_at(K_NB_RD0, "r0_nb_rd", 32'h0, 0);
        expect_at(K_NB_RB0, "r0_nb_rb", 32'h0, 0);
        expect_at(K_CNT,    "r0_cnt",   32'h0, 0);

        // Fill: reserve r1..r31, one per cycle.
        for (int k = 1; k <= 31; k++) begin
            step();
            rsv(AW'(k));
            expect_at(K_CNT, $sformatf("fill_cnt_%0d", k), 32'(k - 1), 0);
        end
        step();
        set_ra(5'd31, 5'd1);
        expect_at(K_CNT,    "full_cnt",  32'd31, 0);
        expect_at(K_NB_CNT, "full_nbcnt", 32'd31, 0);
        expect_at(K_NB_RB0, "full_rb31", 32'h1, 0);
        expect_at(K_RB1,    "full_rb1",  32'h1, 0);
        // Re-reserving a busy register leaves the count alone.
        rsv(5'd4);

        // Drain: two completions per cycle.
        for (int m = 0; m < 15; m++) begin
            step();
            wr(0, AW'(2*m + 1), 32'h0, 4'h0);
            wr(1, AW'(2*m + 2), 32'h0, 4'h0);
            expect_at(K_CNT, $sformatf("drain_cnt_%0d", m), 32'(31 - 2*m), 0);
        end
        step();
        wr(0, 5'd31, 32'h0, 4'hF);
        wr(1, 5'd31, 32'h0, 4'hF);
        expect_at(K_CNT, "drain_last", 32'd1, 0);
        step();
        wr(0, 5'd5, 32'h5, 4'hF);
        expect_at(K_CNT, "drain_zero", 32'd0, 0);
        step();
        set_ra(5'd31, 5'd5);
        expect_at(K_CNT,    "no_underflow",    32'd0, 0);
        expect_at(K_NB_CNT, "no_underflow_nb", 32'd0, 0);
        expect_at(K_RB0,    "drain_rb31",      32'h0, 0);
        expect_at(K_RD1,    "drain_r5",        32'h5, 0);

        step();
        step();
        if (q.size() != 0) begin
            n_total += q.size();
            $display("FAIL leftover: %0d expectations never checked, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the pipelined CPU datapath. It generalises the single-write, two-read 32x32 register file in four ways:
- configurable width, depth and number of read/write ports;
- per-byte write enables;
- optional same-cycle write-to-read bypass;
- a per-register busy scoreboard that lets issue logic detect pending writes.

It sits between decode (reads, reservations) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
NUM_RD, 2, number of read ports.
NUM_WR, 2, number of write ports; a higher index has higher priority.
BYPASS, 1, 1 = read data and busy reflect the same-cycle write; 0 = registered state only.
ZERO_REG, 1, 1 = register 0 reads as 0 and is never written or reserved.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
ra  in  NUM_RD*ADDR_W  read addresses; port i uses slice i.
rdata  out  NUM_RD*DATA_W  read data, combinational.
rbusy  out  NUM_RD  1 = register at ra[i] has a pending write.
we  in  NUM_WR  write enable per port.
wa  in  NUM_WR*ADDR_W  write addresses.
wdata  in  NUM_WR*DATA_W  write data.
wbe  in  NUM_WR*DATA_W/8  byte enables; a byte is written only if we[j] and wbe[j][b] are both 1.
rsv_en  in  1  mark register rsv_addr busy.
rsv_addr  in  ADDR_W  register to reserve.
busy_cnt  out  ADDR_W+1  number of registers currently busy, registered.

Behaviour:
- Reset: when rst_n=0 at a rising edge, every register is cleared to 0, every busy bit to 0, and busy_cnt to 0. All writes and reservations in that cycle are ignored. Reset mid-sequence discards pending reservations.
- Writes take effect at the rising edge, with 1-cycle latency to the registered state.
- Multiple writes to the same address in one cycle resolve per byte: the highest-index port with that byte enabled wins.
- Write completion: any we[j]=1 to address A clears busy[A] at the edge, regardless of wbe.
- Reservation: rsv_en=1 sets busy[rsv_addr] at the edge.
  - A reservation and a write to the same address in the same cycle leave the data written and busy=1, because the reservation is for a newer producer.
- Reads with BYPASS=1:
  - rdata[i] is the registered value with the bytes of any same-cycle enabled write to ra[i] merged in, using the same priority as the registered write.
  - rbusy[i] is busy[ra[i]] AND NOT (any we[j] with wa[j]==ra[i]).
  - A same-cycle reservation is not forwarded.
- Reads with BYPASS=0: rdata and rbusy come purely from registered state.
- With ZERO_REG=1:
  - a read of address 0 returns 0 and rbusy=0;
  - writes and reservations to address 0 are dropped;
  - busy[0] is never set.
- busy_cnt equals the popcount of the busy bits after each edge. It is maintained incrementally (+1 set, -1 clear, 0 if both or neither) and never exceeds DEPTH.
- A reservation of an already-busy register, or a write to a non-busy register, causes no count change and no error.
- There are no X outputs after reset. Before the first reset, contents are undefined.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W, ADDR_W;
  - function be_merge(old, new, be) for byte-masked merging;
  - function popcount helper (used for assertions).
- One sub-module, regfile_wr_merge, is natural. It is combinational: given the NUM_WR ports and a target address, it returns the merged data mask/value and a hit flag. It is instantiated once per register for the update and once per read port for the bypass.
- The busy scoreboard and counter stay in the top.

Test Plan:
1. Reset clears all state: write 0xDEADBEEF to r5, assert rst_n=0 for 1 cycle -> rdata(r5)=0, rbusy=0, busy_cnt=0; a write presented during reset is not stored.
2. Bypass read: BYPASS=1, we[0]=1, wa=7, wdata=0x12345678, ra[0]=7 in the same cycle -> rdata[0]=0x12345678 that cycle; with BYPASS=0, old value 0 that cycle and 0x12345678 next cycle.
3. Byte enables and write priority:
   - r3=0xAAAAAAAA;
   - same cycle: port0 writes 0x11111111 with wbe=1111, port1 writes 0x22222222 with wbe=0011;
   - expected r3=0x11112222.
4. Scoreboard:
   - rsv r9 -> next cycle rbusy(r9)=1, busy_cnt=1;
   - write r9 plus rsv r9 in the same cycle -> data updated, still busy, busy_cnt=1;
   - write r9 alone -> busy clears, busy_cnt=0.
5. Zero register: write 0xFFFFFFFF to r0 and rsv r0 -> rdata(r0)=0, rbusy=0, busy_cnt unchanged.
6. Reserve all 31 nonzero registers over 31 cycles -> busy_cnt=31; then 2 writes per cycle clear them -> busy_cnt decrements by 2 per cycle, reaches 0 with no underflow.
